// File: rtl/umem_arbiter.sv
// Unified-memory arbiter: I-fill, D-fill and D-writeback share one memory port, with a watchdog.
// Optional I-fill fairness against back-to-back D transfers is enabled by UMEM_ARB_FAIR_EN.
module umem_arbiter #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_rd_req,
  input  logic              d_wb_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_rd_done,
  output logic              d_wb_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              err
);

`ifdef UMEM_ARB_FAIR_EN
  localparam bit FairEn = 1'b1;
`else
  localparam bit FairEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIRd, StDRd, StDWb} state_e;

  state_e              r_state;
  logic [7:0]          r_wdog;
  logic                r_last_d;
  logic                r_i_done, r_d_rd_done, r_d_wb_done;
  logic [LINE_W-1:0]   r_i_rdata, r_d_rdata;
  logic                r_mem_re, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic                r_busy, r_err;

  logic                w_i, w_rd, w_wb;
  logic                w_gnt_i, w_gnt_rd, w_gnt_wb;
  logic                w_wdog_exp;
  logic [LINE_W-1:0]   w_rdata;

  always_comb begin
    // A requester still holding its request in its own done cycle is not regranted.
    w_i  = i_req    & ~r_i_done;
    w_rd = d_rd_req & ~r_d_rd_done;
    w_wb = d_wb_req & ~r_d_wb_done;
    w_gnt_i  = w_i & (~(w_wb | w_rd) | (FairEn & r_last_d));
    w_gnt_wb = w_wb & ~w_gnt_i;
    w_gnt_rd = w_rd & ~w_wb & ~w_gnt_i;
    w_wdog_exp = (r_wdog == 8'(TIMEOUT - 1));
    w_rdata    = mem_rdy ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_wdog      <= '0;
      r_last_d    <= 1'b1;
      r_i_done    <= 1'b0;
      r_d_rd_done <= 1'b0;
      r_d_wb_done <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_i_done    <= 1'b0;
      r_d_rd_done <= 1'b0;
      r_d_wb_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_wdog <= '0;
          if (w_gnt_wb) begin
            r_state     <= StDWb;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= d_wb_addr;
            r_mem_wdata <= d_wdata;
            r_busy      <= 1'b1;
            r_last_d    <= 1'b1;
          end else if (w_gnt_rd) begin
            r_state    <= StDRd;
            r_mem_re   <= 1'b1;
            r_mem_addr <= d_addr;
            r_busy     <= 1'b1;
            r_last_d   <= 1'b1;
          end else if (w_gnt_i) begin
            r_state    <= StIRd;
            r_mem_re   <= 1'b1;
            r_mem_addr <= i_addr;
            r_busy     <= 1'b1;
            r_last_d   <= 1'b0;
          end
        end
        StIRd, StDRd, StDWb: begin
          // mem_rdy takes precedence over an expiring watchdog.
          if (mem_rdy || w_wdog_exp) begin
            r_state  <= StIdle;
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
            if (!mem_rdy) r_err <= 1'b1;
            if (r_state == StIRd) begin
              r_i_done  <= 1'b1;
              r_i_rdata <= w_rdata;
            end else if (r_state == StDRd) begin
              r_d_rd_done <= 1'b1;
              r_d_rdata   <= w_rdata;
            end else begin
              r_d_wb_done <= 1'b1;
            end
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign i_done    = r_i_done;
  assign i_rdata   = r_i_rdata;
  assign d_rd_done = r_d_rd_done;
  assign d_wb_done = r_d_wb_done;
  assign d_rdata   = r_d_rdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
